// File: rtl/act_buffer_pkg.sv
// Shared definitions for the activation buffer and the layer blocks that talk to it.
//   LINE_W / BYTE_W / LANES : line geometry (1024-bit lines, 128 byte lanes)
//   DEFAULT_ADDR_BASE       : line address of line 0 of the activation window
//   state_e                 : buffer FSM states
//   addr_in_window()        : wrap-free window test used by the buffer decode
package act_buffer_pkg;

    localparam int unsigned LINE_W     = 1024;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LANES      = LINE_W / BYTE_W;
    localparam int unsigned LANE_IDX_W = $clog2(LANES);

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0000_1000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StServe = 2'd2
    } state_e;

    // base <= addr < base + depth without ever forming base + depth, so a window
    // near the top of the address space cannot wrap.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned depth);
        logic [31:0] offset;
        offset = addr - base;
        return (addr >= base) && (offset < depth);
    endfunction

endpackage

// File: rtl/act_line_mem.sv
// DEPTH x LINE_W line store for the activation buffer.
//   clk, rst      : clock, asynchronous active-high reset (clears lines and rd_data)
//   clr           : synchronous clear of every line; overrides both write ports
//   byte_we/...   : byte-lane write port (byte_line, byte_lane, byte_data)
//   line_we/...   : full-line write port (line_addr, line_data)
//   rd_load       : update rd_data this cycle; otherwise rd_data holds
//   rd_zero       : with rd_load, load zero instead of the addressed line
//   rd_addr       : read line index
//   rd_data       : registered read data (pre-write contents on same-cycle write)
module act_line_mem
    import act_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  byte_we,
    input  logic [IDX_W-1:0]      byte_line,
    input  logic [LANE_IDX_W-1:0] byte_lane,
    input  logic [BYTE_W-1:0]     byte_data,
    input  logic                  line_we,
    input  logic [IDX_W-1:0]      line_addr,
    input  logic [LINE_W-1:0]     line_data,
    input  logic                  rd_load,
    input  logic                  rd_zero,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [LINE_W-1:0]     rd_data
);

    logic [LINE_W-1:0] lines [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lines[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (clr) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    lines[i] <= '0;
                end
            end else begin
                if (line_we) begin
                    lines[line_addr] <= line_data;
                end
                if (byte_we) begin
                    lines[byte_line][{byte_lane, 3'b000} +: BYTE_W] <= byte_data;
                end
            end
            // Samples the array before this edge's writes land.
            if (rd_load) begin
                rd_data <= rd_zero ? '0 : lines[rd_addr];
            end
        end
    end

endmodule

// File: rtl/act_buffer.sv
// Activation buffer: a window of DEPTH 1024-bit lines that is bulk-loaded from an
// image byte stream and then read/written a whole line at a time by a layer.
//   clk, iRst          : clock, asynchronous active-high reset
//   ena, addr          : layer enable and line address (ignored while ena=0)
//   wr_en, wr_data     : full-line write from the layer
//   rd_data            : registered line read data, one-cycle latency
//   addr_err           : sticky out-of-window flag, cleared by iRst or ld_start
//   ld_start           : pulse; (re)starts an image load from any state
//   ld_valid, ld_byte  : image byte stream
//   ld_ready           : bytes are accepted while high (exactly while loading)
//   ld_done, busy      : load complete (level), load in progress
module act_buffer
    import act_buffer_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = DEFAULT_ADDR_BASE,
    parameter int unsigned DEPTH      = 16,   // power of two, >= 2
    parameter int unsigned LOAD_BYTES = 784   // 1 .. DEPTH*LANES
) (
    input  logic              clk,
    input  logic              iRst,
    input  logic              ena,
    input  logic [31:0]       addr,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_data,
    output logic [LINE_W-1:0] rd_data,
    output logic              addr_err,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [BYTE_W-1:0] ld_byte,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Byte counter: upper bits select the line, low LANE_IDX_W bits the lane.
    localparam int unsigned CNT_W = $clog2(DEPTH * LANES);

    state_e           state;
    logic [CNT_W-1:0] cnt;

    logic             in_win;
    logic [IDX_W-1:0] line_idx;
    logic             loading;
    logic             byte_we;
    logic             line_we;
    logic             rd_load;
    logic             rd_zero;
    logic             last_byte;

    assign in_win   = addr_in_window(addr, ADDR_BASE, DEPTH);
    assign line_idx = IDX_W'(addr - ADDR_BASE);

    always_comb begin
        loading   = (state == StLoad);
        last_byte = (cnt == CNT_W'(LOAD_BYTES - 1));
        // A start pulse always wins: the coincident byte or layer write is dropped.
        byte_we   = loading && ld_valid && ld_ready && !ld_start;
        line_we   = ena && wr_en && in_win && !loading && !ld_start;
        // Read port is frozen while ena=0 outside a load; loading forces zeros.
        rd_load   = ld_start || loading || ena;
        rd_zero   = ld_start || loading || !in_win;
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state    <= StIdle;
            cnt      <= '0;
            addr_err <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            busy     <= 1'b0;
        end else if (ld_start) begin
            state    <= StLoad;
            cnt      <= '0;
            addr_err <= 1'b0;
            ld_ready <= 1'b1;
            ld_done  <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                StLoad: begin
                    if (byte_we) begin
                        cnt <= cnt + 1'b1;
                        if (last_byte) begin
                            state    <= StServe;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                StIdle, StServe: begin
                    // Reads and writes both report out-of-window addresses.
                    if (ena && !in_win) begin
                        addr_err <= 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    ld_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    act_line_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst      (iRst),
        .clr      (ld_start),
        .byte_we  (byte_we),
        .byte_line(cnt[CNT_W-1:LANE_IDX_W]),
        .byte_lane(cnt[LANE_IDX_W-1:0]),
        .byte_data(ld_byte),
        .line_we  (line_we),
        .line_addr(line_idx),
        .line_data(wr_data),
        .rd_load  (rd_load),
        .rd_zero  (rd_zero),
        .rd_addr  (line_idx),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_act_buffer.sv
// Self-checking bench for act_buffer: scenario tasks with inline checks; expected
// read data is queued when a read is driven and popped when rd_data is sampled.
module tb_act_buffer;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NLINE = 16;
    localparam int          NBYTE = 784;

    logic          clk = 1'b0;
    logic          iRst;
    logic          ena;
    logic [31:0]   addr;
    logic          wr_en;
    logic [1023:0] wr_data;
    logic [1023:0] rd_data;
    logic          addr_err;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [1023:0] mdl [NLINE];
    logic [1023:0] exp_q [$];

    act_buffer #(
        .ADDR_BASE (BASE),
        .DEPTH     (NLINE),
        .LOAD_BYTES(NBYTE)
    ) dut (
        .clk     (clk),
        .iRst    (iRst),
        .ena     (ena),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .addr_err(addr_err),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_byte (ld_byte),
        .ld_ready(ld_ready),
        .ld_done (ld_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff_lane(input logic [1023:0] a, input logic [1023:0] b);
        for (int k = 0; k < 128; k++) begin
            if (a[k*8 +: 8] !== b[k*8 +: 8]) return k;
        end
        return 0;
    endfunction

    // Expected contents after a full load of bytes valued index % 256.
    task automatic build_std_model();
        for (int l = 0; l < NLINE; l++) mdl[l] = '0;
        for (int i = 0; i < NBYTE; i++) mdl[i / 128][(i % 128) * 8 +: 8] = 8'(i);
    endtask

    task automatic test_reset();
        iRst = 1'b1; ena = 1'b0; addr = '0; wr_en = 1'b0; wr_data = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
        repeat (3) tick();
        total += 5;
        if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got nonzero"); end
        if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        if (ld_done !== 1'b0) begin bad++; $display("FAIL reset_ld_done: got %b want 0", ld_done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        iRst = 1'b0;
        ena = 1'b1; addr = BASE;
        tick();
        total++;
        if (rd_data !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_first_read: busy %b got nonzero or busy", busy);
        end
        ena = 1'b0;
    endtask

    task automatic test_load();
        int early;
        logic [1023:0] got0, got6, exp;
        int k;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        total += 3;
        if (busy !== 1'b1) begin bad++; $display("FAIL load_busy: got %b want 1", busy); end
        if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %b want 1", ld_ready); end
        if (ld_done !== 1'b0) begin bad++; $display("FAIL load_done_low: got %b want 0", ld_done); end
        early = 0;
        for (int i = 0; i < NBYTE; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(i);
            tick();
            if (i < NBYTE - 1 && ld_done !== 1'b0) early++;
        end
        ld_valid = 1'b0;
        total += 4;
        if (early != 0) begin bad++; $display("FAIL load_done_early: got %0d early cycles want 0", early); end
        if (ld_done !== 1'b1) begin bad++; $display("FAIL load_done_rise: got %b want 1", ld_done); end
        if (ld_ready !== 1'b0) begin bad++; $display("FAIL load_ready_drop: got %b want 0", ld_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL load_busy_drop: got %b want 0", busy); end
        build_std_model();
        got0 = '0; got6 = '0;
        for (int l = 0; l < NLINE; l++) begin
            ena = 1'b1; wr_en = 1'b0; addr = BASE + 32'(l);
            exp_q.push_back(mdl[l]);
            tick();
            exp = exp_q.pop_front();
            if (l == 0) got0 = rd_data;
            if (l == 6) got6 = rd_data;
            total++;
            if (rd_data !== exp) begin
                bad++; k = first_diff_lane(rd_data, exp);
                $display("FAIL load_line%0d: lane %0d got %h want %h", l, k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
            end
        end
        total += 3;
        if (got6[1023:128] !== '0) begin bad++; $display("FAIL load_line6_tail: got nonzero want zero"); end
        if (got0[47:40] !== 8'h05) begin bad++; $display("FAIL load_line0_lane5: got %h want 05", got0[47:40]); end
        if (ld_done !== 1'b1) begin bad++; $display("FAIL load_done_level: got %b want 1", ld_done); end
    endtask

    task automatic test_backpressure();
        int idx, cyc, rdy_high;
        logic v, acc;
        logic [1023:0] exp;
        int k;
        total++;
        if (ld_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_serve: got %b want 0", ld_ready); end
        ena = 1'b0;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < NBYTE && cyc < 5000) begin
            v = 1'($urandom_range(0, 1));
            ld_valid = v; ld_byte = 8'(idx);
            acc = v && ld_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        ld_valid = 1'b0;
        total += 2;
        if (idx != NBYTE) begin bad++; $display("FAIL bp_progress: got %0d bytes want %0d", idx, NBYTE); end
        if (ld_done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", ld_done); end
        build_std_model();
        rdy_high = 0;
        for (int l = 0; l < NLINE; l++) begin
            ena = 1'b1; wr_en = 1'b0; addr = BASE + 32'(l);
            exp_q.push_back(mdl[l]);
            tick();
            exp = exp_q.pop_front();
            if (ld_ready !== 1'b0) rdy_high++;
            total++;
            if (rd_data !== exp) begin
                bad++; k = first_diff_lane(rd_data, exp);
                $display("FAIL bp_line%0d: lane %0d got %h want %h", l, k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
            end
        end
        total++;
        if (rdy_high != 0) begin bad++; $display("FAIL bp_ready_outside: got %0d high cycles want 0", rdy_high); end
    endtask

    task automatic test_read_range();
        logic [1023:0] exp;
        logic [31:0] seq [5];
        int k;
        seq[0] = BASE + 32'd3; seq[1] = 32'h0000_1010; seq[2] = 32'h0000_0FFF;
        seq[3] = BASE + 32'd3; seq[4] = BASE + 32'd15;
        total++;
        if (addr_err !== 1'b0) begin bad++; $display("FAIL range_err_clear: got %b want 0", addr_err); end
        for (int s = 0; s < 5; s++) begin
            ena = 1'b1; wr_en = 1'b0; addr = seq[s];
            if (seq[s] >= BASE && seq[s] < BASE + 32'(NLINE)) exp_q.push_back(mdl[seq[s] - BASE]);
            else exp_q.push_back('0);
            tick();
            exp = exp_q.pop_front();
            total += 2;
            if (rd_data !== exp) begin
                bad++; k = first_diff_lane(rd_data, exp);
                $display("FAIL range_rd%0d: lane %0d got %h want %h", s, k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
            end
            // Error appears with the first out-of-window access and then sticks.
            if (addr_err !== (s >= 1)) begin
                bad++; $display("FAIL range_err%0d: got %b want %b", s, addr_err, s >= 1);
            end
        end
    endtask

    task automatic test_rdw();
        logic [1023:0] exp;
        int k;
        ena = 1'b1; addr = BASE + 32'd2; wr_en = 1'b1; wr_data = {128{8'hAA}};
        exp_q.push_back(mdl[2]);
        tick();
        wr_en = 1'b0;
        mdl[2] = {128{8'hAA}};
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp) begin
            bad++; k = first_diff_lane(rd_data, exp);
            $display("FAIL rdw_old: lane %0d got %h want %h", k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
        end
        exp_q.push_back(mdl[2]);
        tick();
        exp = exp_q.pop_front();
        total += 2;
        if (rd_data !== exp) begin
            bad++; k = first_diff_lane(rd_data, exp);
            $display("FAIL rdw_new: lane %0d got %h want %h", k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
        end
        if (addr_err !== 1'b1) begin bad++; $display("FAIL rdw_err_sticky: got %b want 1", addr_err); end
    endtask

    task automatic test_restart();
        logic [1023:0] exp;
        int k, early;
        ena = 1'b1; addr = BASE + 32'd9; wr_en = 1'b1; wr_data = {128{8'h3C}};
        tick();
        wr_en = 1'b0; ena = 1'b0;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        total += 2;
        if (addr_err !== 1'b0) begin bad++; $display("FAIL restart_err_clear: got %b want 0", addr_err); end
        if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
        for (int i = 0; i < 100; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(i * 3 + 1);
            tick();
        end
        // Restart with a byte presented in the same cycle: the byte must be lost.
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hEE;
        tick();
        ld_start = 1'b0;
        early = 0;
        for (int i = 0; i < NBYTE; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(i);
            tick();
            if (i < NBYTE - 1 && ld_done !== 1'b0) early++;
        end
        ld_valid = 1'b0;
        total += 2;
        if (early != 0) begin bad++; $display("FAIL restart_done_early: got %0d early cycles want 0", early); end
        if (ld_done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", ld_done); end
        build_std_model();
        for (int l = 0; l < NLINE; l++) begin
            ena = 1'b1; wr_en = 1'b0; addr = BASE + 32'(l);
            exp_q.push_back(mdl[l]);
            tick();
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp) begin
                bad++; k = first_diff_lane(rd_data, exp);
                $display("FAIL restart_line%0d: lane %0d got %h want %h", l, k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
            end
        end
    endtask

    task automatic test_oow_write();
        logic [1023:0] exp;
        int k;
        total++;
        if (addr_err !== 1'b0) begin bad++; $display("FAIL oow_err_pre: got %b want 0", addr_err); end
        ena = 1'b1; addr = 32'h0000_1010; wr_en = 1'b1; wr_data = {128{8'h55}};
        exp_q.push_back('0);
        tick();
        wr_en = 1'b0;
        exp = exp_q.pop_front();
        total += 2;
        if (rd_data !== exp) begin bad++; $display("FAIL oow_rd: got nonzero want zero"); end
        if (addr_err !== 1'b1) begin bad++; $display("FAIL oow_err_set: got %b want 1", addr_err); end
        addr = BASE;
        exp_q.push_back(mdl[0]);
        tick();
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp) begin
            bad++; k = first_diff_lane(rd_data, exp);
            $display("FAIL oow_line0_kept: lane %0d got %h want %h", k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
        end
    endtask

    task automatic test_ena_off();
        logic [1023:0] exp;
        int k, unstable, err_bad;
        ena = 1'b1; wr_en = 1'b0; addr = BASE + 32'd4;
        exp_q.push_back(mdl[4]);
        tick();
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp) begin bad++; $display("FAIL ena_pre_read: got mismatching line 4"); end
        ena = 1'b0; addr = 'z; wr_data = 'z; wr_en = 1'bz;
        unstable = 0; err_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rd_data !== mdl[4]) unstable++;
            if (addr_err !== 1'b1) err_bad++;
        end
        total += 2;
        if (unstable != 0) begin bad++; $display("FAIL ena_rd_hold: got %0d changed cycles want 0", unstable); end
        if (err_bad != 0) begin bad++; $display("FAIL ena_err_hold: got %0d changed cycles want 0", err_bad); end
        wr_data = '0;
        for (int l = 0; l < NLINE; l++) begin
            ena = 1'b1; wr_en = 1'b0; addr = BASE + 32'(l);
            exp_q.push_back(mdl[l]);
            tick();
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp) begin
                bad++; k = first_diff_lane(rd_data, exp);
                $display("FAIL ena_line%0d: lane %0d got %h want %h", l, k, rd_data[k*8 +: 8], exp[k*8 +: 8]);
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [1023:0] exp;
        ena = 1'b0;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(i + 9);
            tick();
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
        #2 iRst = 1'b1;
        #1;
        total += 5;
        if (rd_data !== '0) begin bad++; $display("FAIL midrst_rd: got nonzero want zero"); end
        if (addr_err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", addr_err); end
        if (ld_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", ld_ready); end
        if (ld_done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", ld_done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        iRst = 1'b0;
        repeat (4) tick();
        ld_valid = 1'b0;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_no_resume_busy: got %b want 0", busy); end
        if (ld_ready !== 1'b0) begin bad++; $display("FAIL midrst_no_resume_ready: got %b want 0", ld_ready); end
        ena = 1'b1; wr_en = 1'b0; addr = BASE;
        exp_q.push_back('0);
        tick();
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp) begin bad++; $display("FAIL midrst_line0: got nonzero want zero"); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_read_range();
        test_rdw();
        test_restart();
        test_oow_write();
        test_ena_off();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
